// File: rtl/mem_pkg.sv
// Shared types and constants for the data-side main-memory controller.
// Imported by the controller and its RAM array.
package mem_pkg;

   localparam int unsigned WORD_WIDTH = 32;
   localparam int unsigned BE_WIDTH   = WORD_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port byte-enabled RAM with a registered read port.
// Contents are never reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS_LOG2 = 16
) (
   input  logic                      clk_i,
   input  logic                      en_i,
   input  logic                      we_i,
   input  logic [BE_WIDTH-1:0]       be_i,
   input  logic [MEM_WORDS_LOG2-1:0] idx_i,
   input  logic [WORD_WIDTH-1:0]     wdata_i,
   output logic [WORD_WIDTH-1:0]     rdata_o
);

   logic [WORD_WIDTH-1:0] mem_q [2**MEM_WORDS_LOG2];
   logic [WORD_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
               if (be_i[b]) begin
                  mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency main-memory controller serving data-cache fills and
// write-backs over a valid/ready request and a one-cycle response pulse.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned              ADDRESS_WIDTH     = 32,
   parameter int unsigned              DATA_WIDTH        = 32,
   parameter int unsigned              BYTE_OFFSET_WIDTH = 2,
   parameter int unsigned              MEM_WORDS_LOG2    = 16,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR         = '0,
   parameter int unsigned              LATENCY           = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0]    req_wdata_i,
   input  logic [BE_WIDTH-1:0]      req_be_i,
   output logic                     resp_valid_o,
   output logic [DATA_WIDTH-1:0]    resp_rdata_o,
   output logic                     resp_err_o
);

   localparam int unsigned AW1 = ADDRESS_WIDTH + 1;
   localparam logic [AW1-1:0] LO_ADDR = AW1'(BASE_ADDR);
   localparam logic [AW1-1:0] HI_ADDR =
      LO_ADDR + (AW1'(1) << (MEM_WORDS_LOG2 + BYTE_OFFSET_WIDTH));

   mem_state_t               state_q;
   logic [3:0]               cnt_q;
   logic                     we_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [BE_WIDTH-1:0]      be_q;
   logic                     ready_q;
   logic                     valid_q;
   logic                     rsel_q;
   logic                     err_q;

   logic                      illegal;
   logic                      access;
   logic                      ram_en;
   logic [ADDRESS_WIDTH-1:0]  off;
   logic [MEM_WORDS_LOG2-1:0] idx;
   logic [DATA_WIDTH-1:0]     ram_rdata;

   assign off = addr_q - BASE_ADDR;
   assign idx = MEM_WORDS_LOG2'(off >> BYTE_OFFSET_WIDTH);

   // Range test is done one bit wider so the top bound cannot overflow.
   assign illegal = (|addr_q[BYTE_OFFSET_WIDTH-1:0])
                 || ({1'b0, addr_q} < LO_ADDR)
                 || ({1'b0, addr_q} >= HI_ADDR);

   assign access = (state_q == WAIT) && (cnt_q == 4'd0);
   assign ram_en = access && !illegal;

   mem_array #(
      .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
   ) u_array (
      .clk_i  (clk_i),
      .en_i   (ram_en),
      .we_i   (we_q),
      .be_i   (be_q),
      .idx_i  (idx),
      .wdata_i(wdata_q),
      .rdata_o(ram_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rsel_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_valid_i && ready_q) begin
                  we_q    <= req_we_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  be_q    <= req_be_i;
                  cnt_q   <= 4'(LATENCY - 1);
                  state_q <= WAIT;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  rsel_q  <= !illegal && !we_q;
                  err_q   <= illegal;
                  valid_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // RAM read register only moves on a read access, so this holds.
   assign resp_rdata_o = rsel_q ? ram_rdata : '0;
   assign resp_err_o   = err_q;
   assign resp_valid_o = valid_q;
   assign req_ready_o  = ready_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Word-addressed main-memory controller that sits directly downstream of the data cache. It services that cache's fill reads and write-back writes. Each request is accepted over a valid/ready handshake, held for a configurable access latency, committed to an internal byte-enabled RAM, and answered with a one-cycle response pulse. Latency is a parameter so the bench can exercise cache stall paths with realistic miss penalties.

## Interface
- `ADDRESS_WIDTH`, default 32: request address width (byte address).
- `DATA_WIDTH`, default 32: word width; must equal 32.
- `BYTE_OFFSET_WIDTH`, default 2: low address bits that select a byte within a word.
- `MEM_WORDS_LOG2`, default 16: RAM depth is 2**MEM_WORDS_LOG2 words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.
- `LATENCY`, default 4: WAIT cycles per request; legal range is 1 to 15.
- `clk_i` input, 1 bit: the single clock.
- `rst_ni` input, 1 bit: reset, asynchronous assertion, active-low.
- `req_valid_i` input, 1 bit: request present.
- `req_ready_o` output, 1 bit: controller can accept a request.
- `req_we_i` input, 1 bit: 1 = write, 0 = read.
- `req_addr_i` input, ADDRESS_WIDTH bits: byte address.
- `req_wdata_i` input, DATA_WIDTH bits: write data.
- `req_be_i` input, 4 bits: byte enables for writes; ignored on reads.
- `resp_valid_o` output, 1 bit: one-cycle pulse marking request completion.
- `resp_rdata_o` output, DATA_WIDTH bits: read data.
- `resp_err_o` output, 1 bit: request was illegal; qualified by `resp_valid_o`.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready_o` = 1.
  - A transfer happens when `req_valid_i` && `req_ready_o`.
  - On a transfer: capture we/addr/wdata/be into request registers, load counter = LATENCY-1, go to WAIT.
- **WAIT:**
  - `req_ready_o` = 0. `req_valid_i` and all request inputs are ignored; changes on them have no effect.
  - Counter decrements each cycle.
  - On the edge where counter == 0: perform the access, go to RESP.
- **Access:**
  - Word index = (addr - BASE_ADDR) >> 2.
  - Write: update only the lanes whose `be` bit is set. be = 0 is a legal no-op write.
  - Read: register the full word into `resp_rdata_o`.
  - A write also loads `resp_rdata_o` with 0.
- **Error (illegal request):**
  - Illegal means addr[1:0] != 0, addr < BASE_ADDR, or addr >= BASE_ADDR + 4*2**MEM_WORDS_LOG2.
  - No RAM access is made; `resp_rdata_o` = 0, `resp_err_o` = 1.
  - Latency is identical to a legal request.
- **RESP:**
  - `resp_valid_o` = 1 for exactly this cycle; `req_ready_o` = 0; go to IDLE.
  - `resp_rdata_o` and `resp_err_o` hold their values until the next access edge.
- **Requester rule:**
  - Deassert `req_valid_i` in the cycle after the transfer, or present a new request.
  - A `req_valid_i` still high when the FSM returns to IDLE is a new request.
- **Reset:**
  - `rst_ni` low forces state IDLE, counter 0, `resp_valid_o` 0, `resp_rdata_o` 0, `resp_err_o` 0, and `req_ready_o` 0 for the whole time reset is asserted.
  - RAM contents are not reset.
- **Reset mid-operation:** the pending request is dropped with no response. A write whose access edge has not yet occurred is not committed.

## Timing
- Request accepted in cycle 0: WAIT occupies cycles 1..LATENCY, RESP is cycle LATENCY+1.
  - LATENCY=4 gives `resp_valid_o` in cycle 5.
  - LATENCY=1 gives `resp_valid_o` in cycle 2.
- The next request can be accepted in cycle LATENCY+2. Maximum throughput is one request per LATENCY+2 cycles.
- `req_ready_o` and `resp_valid_o` are decoded from the registered state only; there is no combinational path from any input to any output.
- `resp_rdata_o` and `resp_err_o` are registered.
- Counter width is 4 bits. It never wraps, because it is reloaded only in IDLE.

## Structure
- **Package `mem_pkg`:** `mem_state_t` enum (IDLE, WAIT, RESP) and localparam `BE_WIDTH` = DATA_WIDTH/8.
- **Sub-module `mem_array`:** single-port synchronous RAM, 2**MEM_WORDS_LOG2 × 32.
  - Ports: en, we, be[3:0], idx, wdata, rdata.
  - Registered read; write takes effect at the clock edge.
  - No reset.
- **`data_mem_ctrl`:** holds the FSM, request registers, counter, range/alignment check, and response registers.

## Test plan
- **Write then read:** write 32'hDEADBEEF to 0x100 with be=4'hF, then read 0x100 at LATENCY=4 → `resp_valid_o` in cycle 5 of each request; read returns `resp_rdata_o` = 32'hDEADBEEF, `resp_err_o` = 0.
- **Byte lanes:** after the previous test, write 32'h000000AA to 0x100 with be=4'b0001, then read → 32'hDEADBEAA. A write with be=0 leaves the word unchanged.
- **Errors:**
  - Read 0x102 → `resp_err_o` = 1, `resp_rdata_o` = 0, same 5-cycle latency.
  - Write to 0x0004_0000 with MEM_WORDS_LOG2=16 → `resp_err_o` = 1; a read of 0x0 afterwards shows no RAM change.
- **Handshake:**
  - Change req_addr_i and req_we_i during WAIT → ignored, `req_ready_o` stays 0.
  - Hold `req_valid_i` high through RESP → a second transfer is accepted in cycle 6, and its response arrives in cycle 11.
- **Reset mid-op:** start a write of 32'h12345678 to 0x200 (prior value 32'h0BADF00D), then pull `rst_ni` low in WAIT cycle 2 → all outputs 0 immediately, no `resp_valid_o`; a read of 0x200 after release returns 32'h0BADF00D.
- **Minimum latency:** with LATENCY=1, a read accepted in cycle 0 → `resp_valid_o` in cycle 2, and back-to-back transfers in cycles 0 and 3.
